uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the board's open-drain UART transmitter: 8 data bits, one start bit, one stop bit, no parity, LSB first. Samples the externally pulled-up serial line, validates the start bit at mid-bit, and delivers each correctly framed byte with a one-cycle valid strobe. Stop-bit errors are flagged and the byte is dropped. Sits between the FPGA's serial RX pin and the command/packet parser.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// UART receive-side bundle: serial line in, framed byte out.
// The master modport is the receiver; the slave modport is the pin driver / byte consumer.
interface uart_rx_if;
    logic       Rx_Serial;
    logic       Rx_DV;
    logic [7:0] Rx_Byte;
    logic       Rx_Frame_Err;
    logic       Rx_Active;

    modport master (
        input  Rx_Serial,
        output Rx_DV,
        output Rx_Byte,
        output Rx_Frame_Err,
        output Rx_Active
    );

    modport slave (
        output Rx_Serial,
        input  Rx_DV,
        input  Rx_Byte,
        input  Rx_Frame_Err,
        input  Rx_Active
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling. Good bytes are delivered with a
// one-cycle valid strobe; a stop bit sampled low raises a one-cycle frame error and
// the byte is dropped.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic     i_Clock,
    input  logic     i_Reset_n,
    uart_rx_if.master rx_if
);

    // Count at which the start bit is re-checked (middle of the start bit).
    localparam logic [8:0] HALF_CNT = 9'((CLKS_PER_BIT - 1) / 2);
    // Count at which a data/stop bit is sampled (one full bit after the previous sample).
    localparam logic [8:0] LAST_CNT = 9'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StCleanup  = 3'd4,
        StWaitIdle = 3'd5
    } state_e;

    logic       sync1_q;
    logic       sync2_q;
    logic       rx_s;

    state_e     state_q;
    logic [8:0] count_q;
    logic [2:0] index_q;
    logic [7:0] shift_q;
    logic [7:0] byte_q;
    logic       dv_q;
    logic       err_q;
    logic       active_q;

    // Two-flop synchronizer; resets to the idle (mark) level so reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_if.Rx_Serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Receive FSM with registered outputs; strobes default low so they last one cycle.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            index_q  <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    count_q  <= '0;
                    index_q  <= '0;
                    active_q <= 1'b0;
                    if (!rx_s) begin
                        state_q <= StStart;
                    end
                end

                StStart: begin
                    if (count_q == HALF_CNT) begin
                        count_q <= '0;
                        if (!rx_s) begin
                            state_q  <= StData;
                            active_q <= 1'b1;
                        end else begin
                            // Low pulse shorter than half a bit: not a start bit.
                            state_q <= StIdle;
                        end
                    end else begin
                        count_q <= count_q + 9'd1;
                    end
                end

                StData: begin
                    if (count_q == LAST_CNT) begin
                        count_q          <= '0;
                        shift_q[index_q] <= rx_s;
                        if (index_q < 3'd7) begin
                            index_q <= index_q + 3'd1;
                        end else begin
                            index_q <= '0;
                            state_q <= StStop;
                        end
                    end else begin
                        count_q <= count_q + 9'd1;
                    end
                end

                StStop: begin
                    if (count_q == LAST_CNT) begin
                        count_q  <= '0;
                        active_q <= 1'b0;
                        if (rx_s) begin
                            byte_q  <= shift_q;
                            dv_q    <= 1'b1;
                            state_q <= StCleanup;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StWaitIdle;
                        end
                    end else begin
                        count_q <= count_q + 9'd1;
                    end
                end

                StCleanup: begin
                    state_q <= StIdle;
                end

                StWaitIdle: begin
                    // Break (line held low) yields a single error pulse: wait for mark level.
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q  <= StIdle;
                    count_q  <= '0;
                    index_q  <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.Rx_DV        = dv_q;
    assign rx_if.Rx_Byte      = byte_q;
    assign rx_if.Rx_Frame_Err = err_q;
    assign rx_if.Rx_Active    = active_q;

`ifndef SYNTHESIS
    // Strobe sanity: valid and error are exclusive and each lasts exactly one cycle.
    a_dv_err_excl : assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
        !(dv_q && err_q));
    a_dv_single : assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
        dv_q |=> !dv_q);
    a_err_single : assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
        err_q |=> !err_q);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    logic tx_low;
    int   cyc = 0;

    uart_rx_if rx_if ();

    // Open-drain line: released (pulled up) reads 1.
    assign rx_if.Rx_Serial = tx_low ? 1'b0 : 1'b1;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .rx_if     (rx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] dv_bytes[$];
    int         dv_cycs[$];
    int         err_cnt     = 0;
    int         err_cyc     = 0;
    int         both_hi     = 0;
    int         dv_long     = 0;
    int         err_long    = 0;
    bit         active_seen = 0;
    bit         prev_dv     = 0;
    bit         prev_err    = 0;

    // Observe outputs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (rx_if.Rx_DV) begin
            dv_bytes.push_back(rx_if.Rx_Byte);
            dv_cycs.push_back(cyc);
        end
        if (rx_if.Rx_Frame_Err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (rx_if.Rx_Active) active_seen = 1;
        if (rx_if.Rx_DV && rx_if.Rx_Frame_Err) both_hi = both_hi + 1;
        if (rx_if.Rx_DV && prev_dv) dv_long = dv_long + 1;
        if (rx_if.Rx_Frame_Err && prev_err) err_long = err_long + 1;
        prev_dv  = rx_if.Rx_DV;
        prev_err = rx_if.Rx_Frame_Err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the line at one level for one bit time; entered and left 1 unit after a rising edge.
    task automatic send_bit(input logic level);
        tx_low = ~level;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Start, 8 data bits LSB first, stop bit; line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        tx_low = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s;
    int base;
    int e0;
    int n0;
    logic [7:0] bb3[3];

    initial begin
        rst_n  = 1'b0;
        tx_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dv", 32'(rx_if.Rx_DV), 32'd0);
        check("reset_err", 32'(rx_if.Rx_Frame_Err), 32'd0);
        check("reset_active", 32'(rx_if.Rx_Active), 32'd0);
        check("reset_byte", 32'(rx_if.Rx_Byte), 32'h00);
        rst_n = 1'b1;
        idle(5);

        // Good frame 0xA5; DV at edge 154 relative to first low sample.
        s = cyc + 1;
        send_frame(8'hA5, 1'b1);
        check("a5_dv_count", 32'(dv_bytes.size()), 32'd1);
        if (dv_bytes.size() >= 1) begin
            check("a5_byte", 32'(dv_bytes[0]), 32'hA5);
            check("a5_latency", 32'(dv_cycs[0] - s), 32'd154);
        end
        check("a5_no_err", 32'(err_cnt), 32'd0);
        check("a5_byte_held", 32'(rx_if.Rx_Byte), 32'hA5);
        idle(20);

        // Back-to-back 0x00, 0xFF, 0x55 with no idle gap.
        base   = dv_bytes.size();
        bb3[0] = 8'h00;
        bb3[1] = 8'hFF;
        bb3[2] = 8'h55;
        s      = cyc + 1;
        for (int i = 0; i < 3; i++) send_frame(bb3[i], 1'b1);
        check("b2b_count", 32'(dv_bytes.size() - base), 32'd3);
        if (dv_bytes.size() == base + 3) begin
            for (int i = 0; i < 3; i++) check("b2b_byte", 32'(dv_bytes[base + i]), 32'(bb3[i]));
            check("b2b_latency", 32'(dv_cycs[base] - s), 32'd154);
            check("b2b_gap1", 32'(dv_cycs[base + 1] - dv_cycs[base]), 32'd160);
            check("b2b_gap2", 32'(dv_cycs[base + 2] - dv_cycs[base + 1]), 32'd160);
        end
        check("b2b_no_err", 32'(err_cnt), 32'd0);
        idle(20);

        // 4-cycle glitch: rejected at the mid-start check.
        active_seen = 0;
        n0 = dv_bytes.size();
        e0 = err_cnt;
        tx_low = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        check("glitch_no_dv", 32'(dv_bytes.size()), 32'(n0));
        check("glitch_no_err", 32'(err_cnt), 32'(e0));
        check("glitch_no_active", 32'(active_seen), 32'd0);

        // Frame 0x3C with stop bit 0, then break for 100 cycles.
        n0 = dv_bytes.size();
        s  = cyc + 1;
        send_frame(8'h3C, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        idle(20);
        check("ferr_count", 32'(err_cnt), 32'(e0 + 1));
        check("ferr_cycle", 32'(err_cyc - s), 32'd154);
        check("ferr_no_dv", 32'(dv_bytes.size()), 32'(n0));
        check("ferr_byte_kept", 32'(rx_if.Rx_Byte), 32'h55);
        send_frame(8'h81, 1'b1);
        check("after_ferr_count", 32'(dv_bytes.size()), 32'(n0 + 1));
        if (dv_bytes.size() == n0 + 1) check("after_ferr_byte", 32'(dv_bytes[n0]), 32'h81);
        idle(20);

        // Reset during bit 4 of a frame whose remaining bits are all 1.
        n0 = dv_bytes.size();
        e0 = err_cnt;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #2;
                check("rst_active_before", 32'(rx_if.Rx_Active), 32'd1);
                rst_n = 1'b0;
                #1;
                check("rst_async_active", 32'(rx_if.Rx_Active), 32'd0);
                check("rst_async_byte", 32'(rx_if.Rx_Byte), 32'h00);
                check("rst_async_dv", 32'(rx_if.Rx_DV), 32'd0);
                check("rst_async_err", 32'(rx_if.Rx_Frame_Err), 32'd0);
                #20;
                rst_n = 1'b1;
            end
        join
        idle(20);
        check("rst_no_dv", 32'(dv_bytes.size()), 32'(n0));
        check("rst_no_err", 32'(err_cnt), 32'(e0));
        send_frame(8'h12, 1'b1);
        check("after_rst_count", 32'(dv_bytes.size()), 32'(n0 + 1));
        if (dv_bytes.size() == n0 + 1) check("after_rst_byte", 32'(dv_bytes[n0]), 32'h12);
        idle(20);

        // Loopback-style stream of every byte value, some back-to-back, some gapped.
        n0 = dv_bytes.size();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1);
            if (i % 2 == 1) idle(3);
        end
        idle(20);
        check("loop_count", 32'(dv_bytes.size() - n0), 32'd256);
        if (dv_bytes.size() == n0 + 256) begin
            for (int i = 0; i < 256; i++) check("loop_byte", 32'(dv_bytes[n0 + i]), 32'(i));
        end
        check("loop_no_err", 32'(err_cnt), 32'(e0));

        check("dv_err_never_both", 32'(both_hi), 32'd0);
        check("dv_one_cycle", 32'(dv_long), 32'd0);
        check("err_one_cycle", 32'(err_long), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
